biu_arb_n: RTL

Parametrised successor to the two-port picoJava bus interface unit. It arbitrates NUM_CH requesters (ICU, DCU, plus optional DMA or debug ports) onto the single pj_* memory bus. Supports round-robin or fixed priority, wrapping bursts of BURST_LEN beats, and a no-ack timeout that returns an error ack. Sits between the cache units and the external memory controller and replaces the fixed ICU/DCU mux.

---
 rtl/biu_pkg.sv | 21 ++
 rtl/biu_arb_n_if.sv | 35 +++
 rtl/biu_rr_arb.sv | 43 ++++
 rtl/biu_arb_n.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// rtl/biu_pkg.sv - shared ack encodings, type bit positions and FSM states for biu_arb_n
// Ports: none (package).
package biu_pkg;

  // Ack encoding, shared by pj_ack and the per-channel ch_ack fields.
  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_OK   = 2'b01;
  localparam logic [1:0] ACK_MERR = 2'b10;
  localparam logic [1:0] ACK_TOUT = 2'b11;

  // Bit positions inside the 4-bit transfer type.
  localparam int TYPE_WR_BIT    = 0;
  localparam int TYPE_BURST_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } biu_state_e;

endpackage

// File: rtl/biu_arb_n_if.sv
// rtl/biu_arb_n_if.sv - requester-side and pj-side bus bundle for biu_arb_n
// Signals:
//   ch_req/ch_addr/ch_type/ch_size/ch_wdata : flattened per-channel requests
//   ch_ack (2b per channel), biu_data        : per-channel responses
//   pj_*                                     : single external memory bus
// Modports: master = the BIU, slave = requesters plus memory controller.
interface biu_arb_n_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH*32-1:0] ch_addr;
  logic [NUM_CH*4-1:0]  ch_type;
  logic [NUM_CH*2-1:0]  ch_size;
  logic [NUM_CH*32-1:0] ch_wdata;
  logic [NUM_CH*2-1:0]  ch_ack;
  logic [31:0]          biu_data;
  logic [29:0]          pj_addr;
  logic [31:0]          pj_data_out;
  logic [31:0]          pj_data_in;
  logic                 pj_tv;
  logic                 pj_ale;
  logic [1:0]           pj_size;
  logic [3:0]           pj_type;
  logic [1:0]           pj_ack;

  modport master (
    input  ch_req, ch_addr, ch_type, ch_size, ch_wdata, pj_data_in, pj_ack,
    output ch_ack, biu_data, pj_addr, pj_data_out, pj_tv, pj_ale, pj_size, pj_type
  );

  modport slave (
    output ch_req, ch_addr, ch_type, ch_size, ch_wdata, pj_data_in, pj_ack,
    input  ch_ack, biu_data, pj_addr, pj_data_out, pj_tv, pj_ale, pj_size, pj_type
  );
endinterface

// File: rtl/biu_rr_arb.sv
// rtl/biu_rr_arb.sv - combinational round-robin / fixed-priority request arbiter
// Ports:
//   req_i [NUM_CH]  request vector
//   ptr_i [IW]      round-robin start index (ignored when RR_EN = 0)
//   gnt_o [NUM_CH]  one-hot grant
//   idx_o [IW]      binary index of the grant
//   any_o           at least one request present
module biu_rr_arb #(
  parameter int NUM_CH = 2,
  parameter int RR_EN  = 1,
  localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  // Two passes stand in for a rotating search: the first only considers
  // indices at or above the pointer, the second wraps back to index 0.
  // In fixed mode the first pass already covers every index.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_o && req_i[i] && ((RR_EN == 0) || (i >= int'(ptr_i)))) begin
        any_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_o && req_i[i]) begin
        any_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/biu_arb_n.sv
// rtl/biu_arb_n.sv - NUM_CH-way arbiter onto the pj_* memory bus with bursts and timeout
// Ports:
//   clk    core clock
//   reset  asynchronous active-high reset
//   bus    biu_arb_n_if.master: per-channel requests/acks and the pj_* bus
module biu_arb_n
  import biu_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 255,
  parameter int RR_EN     = 1
) (
  input  logic       clk,
  input  logic       reset,
  biu_arb_n_if.master bus
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(BURST_LEN);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_ADDR = ST_ADDR;
  localparam logic [1:0] S_DATA = ST_DATA;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [29:0]   addr_q, addr_d;
  logic [3:0]    type_q, type_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [15:0]   timer_q, timer_d;

  logic [NUM_CH-1:0] gnt_oh;
  logic [IW-1:0]     win_idx;
  logic              any_req;

  logic [31:0] sel_addr;
  logic [3:0]  sel_type;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic        unused_addr_lsb;

  logic        tout;
  logic [1:0]  ack_v;
  logic [NUM_CH*2-1:0] ch_ack_c;
  logic [29:0] wrap_addr;

  biu_rr_arb #(
    .NUM_CH (NUM_CH),
    .RR_EN  (RR_EN)
  ) u_arb (
    .req_i (bus.ch_req),
    .ptr_i (rr_q),
    .gnt_o (gnt_oh),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  // AND-OR mux of the winning channel's fields, driven by the one-hot grant.
  always_comb begin
    sel_addr  = '0;
    sel_type  = '0;
    sel_size  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_oh[i]) begin
        sel_addr  = sel_addr  | bus.ch_addr[32*i +: 32];
        sel_type  = sel_type  | bus.ch_type[4*i +: 4];
        sel_size  = sel_size  | bus.ch_size[2*i +: 2];
        sel_wdata = sel_wdata | bus.ch_wdata[32*i +: 32];
      end
    end
  end

  // Byte offset within a word never reaches the word-addressed bus.
  assign unused_addr_lsb = ^sel_addr[1:0];

  // Advance within the aligned BURST_LEN-word block: only the low BW bits count.
  assign wrap_addr = {addr_q[29:BW], addr_q[BW-1:0] + BW'(1)};

  assign tout = (state_q == S_DATA) && (timer_q == 16'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    type_d  = type_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ADDR;
          gidx_d  = win_idx;
          addr_d  = sel_addr[31:2];
          type_d  = sel_type;
          size_d  = sel_size;
          wdata_d = sel_wdata;
          beat_d  = '0;
          timer_d = '0;
          if (RR_EN != 0) begin
            rr_d = (int'(win_idx) == NUM_CH - 1) ? '0 : win_idx + IW'(1);
          end
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        if (tout) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          case (bus.pj_ack)
            ACK_NONE: timer_d = timer_q + 16'd1;
            ACK_OK: begin
              timer_d = '0;
              beat_d  = beat_q + BW'(1);
              if (!type_q[TYPE_BURST_BIT] || (beat_q == BW'(BURST_LEN - 1))) begin
                state_d = S_IDLE;
              end else begin
                addr_d = wrap_addr;
              end
            end
            default: begin
              // Memory error or bus error: abandon the rest of any burst.
              timer_d = '0;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      timer_q <= timer_d;
    end
  end

  // Acks reach only the granted channel and only while in DATA; a timeout
  // overrides whatever the bus shows in that cycle.
  assign ack_v = tout ? ACK_TOUT : bus.pj_ack;

  always_comb begin
    ch_ack_c = '0;
    if (state_q == S_DATA) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gidx_q == IW'(i)) begin
          ch_ack_c[2*i +: 2] = ack_v;
        end
      end
    end
  end

  assign bus.ch_ack      = ch_ack_c;
  assign bus.biu_data    = bus.pj_data_in;
  assign bus.pj_ale      = (state_q == S_ADDR);
  assign bus.pj_tv       = (state_q == S_ADDR) || ((state_q == S_DATA) && !tout);
  assign bus.pj_addr     = addr_q;
  assign bus.pj_type     = type_q;
  assign bus.pj_size     = size_q;
  assign bus.pj_data_out = wdata_q;

endmodule
